mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port.
- Sits between the processor and the memory, replacing the separate instruction and data memories.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.
- Grants are issued same-cycle; read data returns one cycle after grant and is steered to the requester that owned that grant.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
MAX_WAIT, 4, max consecutive cycles a pending fetch may be denied before it is forced through (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  AW  fetch address (byte)
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
i_rdata  out  DW  fetched instruction word
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address (byte)
d_wdata  in  DW  store data
d_gnt  out  1  data access accepted this cycle
d_rvalid  out  1  d_rdata valid (cycle after a load grant)
d_rdata  out  DW  load data
m_en  out  1  memory access this cycle
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid the cycle after m_en && !m_we

Behaviour:
- Grant selection is combinational, one grant per cycle at most:
  - force = i_req && (wait_cnt >= MAX_WAIT).
  - d_gnt = d_req && !force.
  - i_gnt = i_req && (!d_req || force).
- Memory drive:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_addr = d_gnt ? d_addr : i_addr.
  - m_wdata = d_wdata (don't-care unless m_we).
- Starvation counter wait_cnt (4 bits):
  - Cleared on i_gnt, and when !i_req.
  - Increments when i_req && !i_gnt; saturates at 15.
  - A forced grant (i_gnt while d_req=1) clears it; d_req then wins again next cycle.
- Response-owner register resp_own, one of NONE / INSTR / DATA, updated every cycle:
  - INSTR if i_gnt.
  - DATA if d_gnt && !d_we.
  - NONE otherwise, including stores.
- Responses:
  - i_rvalid = (resp_own == INSTR); i_rdata = m_rdata.
  - d_rvalid = (resp_own == DATA); d_rdata = m_rdata.
  - rdata ports carry m_rdata unconditionally; consumers qualify with rvalid.
- Latency:
  - Grant: 0 cycles from req when uncontended.
  - Read data: exactly 1 cycle after grant.
  - Store: complete at the grant edge; no rvalid.
- Back-to-back: a new grant is allowed in the cycle a response is returned (fully pipelined, 1 access/cycle).
- Simultaneous requests:
  - Data wins unless force.
  - A loser that keeps req asserted is granted in a later cycle; requester inputs are not latched by the arbiter.
- Reset:
  - Reset asserted (async): wait_cnt=0, resp_own=NONE.
  - All outputs then evaluate to 0: i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we all 0 while reset is high, with grants gated by !reset.
  - A read granted in the cycle before reset never produces rvalid.
- Requester protocol violations (req dropped before gnt) are legal: the request is simply withdrawn, and wait_cnt clears.

Decomposition:
- Package mem_arb_pkg: typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e; WAIT_W=4 constant.
- Sub-module arb_starve_cnt: saturating wait counter with clear/inc/force output.
- Grant logic, mux and owner register stay in mem_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: i_req=1, i_addr=0x10 for 3 cycles, memory preloaded.
  - Response: i_gnt=1 each cycle; i_rvalid every cycle from cycle 2 with words at 0x10 in order; d_* outputs 0.
- Load vs fetch contention:
  - Stimulus: d_req=1, d_we=0, d_addr=0x40 and i_req=1 same cycle.
  - Response: d_gnt=1, i_gnt=0, m_addr=0x40; next cycle d_rvalid=1 with mem[0x40], i_rvalid=0.
- Starvation with MAX_WAIT=4:
  - Stimulus: d_req held 1 continuously, i_req held 1.
  - Response: i_gnt=0 for 4 cycles, i_gnt=1 and d_gnt=0 on cycle 5, d_gnt=1 on cycle 6.
- Store then load:
  - Stimulus: store 0xDEADBEEF to 0x80, next cycle load 0x80.
  - Response: m_we=1 on the first cycle with no rvalid; d_rvalid=1 with 0xDEADBEEF one cycle after the load grant.
- Reset mid-operation:
  - Stimulus: grant a fetch, assert reset asynchronously before the next edge.
  - Response: i_rvalid, m_en and all grants 0 immediately; after release, wait_cnt=0 and an uncontended fetch is granted in the first cycle.
- Request withdrawal:
  - Stimulus: i_req high 2 cycles under d_req contention, then low 1 cycle, then high again.
  - Response: wait_cnt returns to 0; forcing occurs only after 4 fresh denied cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   // Width of the fetch starvation counter (saturates at all-ones)
   localparam int WAIT_W = 4;

   // Which requester owns the read data returning next cycle
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles a pending fetch is
// denied and raises force_grant once the limit is reached, so the fetch
// port is guaranteed forward progress against a continuous data stream.
module arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
)
(
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic force_grant
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] ZERO  = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] SAT   = {WAIT_W{1'b1}};

   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_next_s;

   // Next count: clear on grant or withdrawn request, else count up to saturation
   always_comb begin
      wait_cnt_next_s = wait_cnt_r;
      if (gnt || !req) begin
         wait_cnt_next_s = ZERO;
      end else if (wait_cnt_r != SAT) begin
         wait_cnt_next_s = wait_cnt_r + ONE;
      end else begin
         wait_cnt_next_s = wait_cnt_r;
      end
   end

   // Counter register, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_r <= ZERO;
      end else begin
         wait_cnt_r <= wait_cnt_next_s;
      end
   end

   // Force depends only on the registered count, so no combinational loop
   // forms through the grant logic that feeds gnt back in.
   assign force_grant = req && (wait_cnt_r >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous-read memory between the
// instruction-fetch port and the load/store port. Data has priority,
// fetch is forced through after MAX_WAIT denied cycles, grants are
// same-cycle and read data is steered back one cycle later to the port
// that owned the grant.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   logic   force_s;
   owner_e resp_own_r;
   owner_e resp_own_next_s;

   arb_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk         (clk),
      .reset       (reset),
      .req         (i_req),
      .gnt         (i_gnt),
      .force_grant (force_s)
   );

   // Grants are gated by reset so nothing reaches memory while it is held
   assign d_gnt = d_req && !force_s && !reset;
   assign i_gnt = i_req && (!d_req || force_s) && !reset;

   assign m_en    = i_gnt | d_gnt;
   assign m_we    = d_gnt & d_we;
   assign m_addr  = d_gnt ? d_addr : i_addr;
   assign m_wdata = d_wdata;

   // Remember who receives the read data next cycle; stores return nothing
   always_comb begin
      resp_own_next_s = OWN_NONE;
      if (i_gnt) begin
         resp_own_next_s = OWN_INSTR;
      end else if (d_gnt && !d_we) begin
         resp_own_next_s = OWN_DATA;
      end else begin
         resp_own_next_s = OWN_NONE;
      end
   end

   // Owner register; async reset discards any read in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_own_r <= OWN_NONE;
      end else begin
         resp_own_r <= resp_own_next_s;
      end
   end

   // Read data is broadcast; rvalid qualifies which port it belongs to
   assign i_rvalid = (resp_own_r == OWN_INSTR);
   assign d_rvalid = (resp_own_r == OWN_DATA);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model that
// tracks the denied-fetch streak, the owner of the next read and a shadow
// copy of memory contents.
module tb_mem_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata;

   logic        mem_init;
   logic [31:0] mem [0:63];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Model state
   int          exp_wait;
   int          exp_own;       // 0 none, 1 fetch, 2 data
   logic [31:0] exp_rdata;
   logic [31:0] shadow [0:63];
   logic        e_ig, e_dg, have_eval;
   logic [5:0]  exp_vec;
   logic [31:0] exp_addr;

   wire [5:0] vec = {i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid};

   mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Single-port synchronous-read memory attached to the arbiter
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= word_at(i);
      end else if (m_en) begin
         if (m_we) mem[m_addr[7:2]] <= m_wdata;
         else      m_rdata <= mem[m_addr[7:2]];
      end
   end

   // Expected outputs for the inputs currently applied
   task automatic eval();
      logic frc;
      frc      = i_req && (exp_wait >= MAX_WAIT);
      e_dg     = d_req && !frc;
      e_ig     = i_req && (!d_req || frc);
      exp_vec  = {e_ig, e_dg, e_ig | e_dg, e_dg & d_we, exp_own == 1, exp_own == 2};
      exp_addr = e_dg ? d_addr : i_addr;
   endtask

   // Advance the model across the clock edge that consumed the last inputs
   task automatic commit();
      if (e_ig || !i_req) exp_wait = 0;
      else if (exp_wait < 15) exp_wait = exp_wait + 1;
      exp_own = 0;
      if (e_ig) begin
         exp_own = 1; exp_rdata = shadow[i_addr[7:2]];
      end else if (e_dg && !d_we) begin
         exp_own = 2; exp_rdata = shadow[d_addr[7:2]];
      end
      if (e_dg && d_we) shadow[d_addr[7:2]] = d_wdata;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] wd);
      if (have_eval) commit();
      @(negedge clk);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
      #1;
      eval();
      have_eval = 1'b1;
   endtask

   task automatic test_reset();
      chk_cnt++; if (vec !== 6'b0) $display("FAIL reset_outs got %b want 000000", vec); else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++; if (vec !== 6'b0) $display("FAIL reset_held got %b want 000000", vec); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; mem_init = 1'b0;
      #1;
      exp_wait = 0; exp_own = 0;
      eval(); have_eval = 1'b1;
      chk_cnt++; if (vec !== 6'b0) $display("FAIL reset_release got %b want 000000", vec); else pass_cnt++;
   endtask

   task automatic test_fetch_only();
      for (int k = 0; k < 4; k++) begin
         drive(k < 3, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
         chk_cnt++;
         if (vec !== {k < 3, 1'b0, k < 3, 1'b0, k > 0, 1'b0})
            $display("FAIL fetch_vec cyc %0d got %b", k, vec);
         else pass_cnt++;
         if (k > 0) begin
            chk_cnt++;
            if (i_rdata !== word_at(4)) $display("FAIL fetch_rdata got %h want %h", i_rdata, word_at(4));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_contention();
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
      chk_cnt++; if (vec !== 6'b011000) $display("FAIL cont_vec got %b want 011000", vec); else pass_cnt++;
      chk_cnt++; if (m_addr !== 32'h40) $display("FAIL cont_addr got %h want 40", m_addr); else pass_cnt++;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_cnt++; if (vec !== 6'b000001) $display("FAIL cont_resp got %b want 000001", vec); else pass_cnt++;
      chk_cnt++; if (d_rdata !== word_at(16)) $display("FAIL cont_rdata got %h want %h", d_rdata, word_at(16)); else pass_cnt++;
   endtask

   task automatic test_starvation();
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h44, 32'h0);
         chk_cnt++;
         if ({i_gnt, d_gnt} !== {k == 4, k != 4})
            $display("FAIL starve_gnt cyc %0d got %b want %b", k, {i_gnt, d_gnt}, {k == 4, k != 4});
         else pass_cnt++;
         if (k == 5) begin
            chk_cnt++;
            if (i_rvalid !== 1'b1 || i_rdata !== word_at(5))
               $display("FAIL starve_rdata got %b/%h want 1/%h", i_rvalid, i_rdata, word_at(5));
            else pass_cnt++;
         end
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_store_load();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
      chk_cnt++; if (vec !== 6'b011100) $display("FAIL st_vec got %b want 011100", vec); else pass_cnt++;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      chk_cnt++; if (vec !== 6'b011000) $display("FAIL ld_vec got %b want 011000", vec); else pass_cnt++;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_cnt++; if (vec !== 6'b000001) $display("FAIL ld_resp got %b want 000001", vec); else pass_cnt++;
      chk_cnt++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL ld_rdata got %h want deadbeef", d_rdata); else pass_cnt++;
   endtask

   task automatic test_withdrawal();
      for (int k = 0; k < 8; k++) begin
         drive(k != 2, 32'h18, 1'b1, 1'b0, 32'h48, 32'h0);
         chk_cnt++;
         if ({i_gnt, d_gnt} !== {k == 7, k != 7})
            $display("FAIL withdraw_gnt cyc %0d got %b want %b", k, {i_gnt, d_gnt}, {k == 7, k != 7});
         else pass_cnt++;
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_cnt++; if (i_gnt !== 1'b1) $display("FAIL rm_fetch got %b want 1", i_gnt); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h1C, 1'b1, 1'b0, 32'h4C, 32'h0);
         chk_cnt++;
         if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== {1'b0, 1'b1, k == 0, k != 0})
            $display("FAIL rm_pre cyc %0d got %b", k, {i_gnt, d_gnt, i_rvalid, d_rvalid});
         else pass_cnt++;
      end
      #2 rst = 1'b1;
      #1;
      chk_cnt++; if (vec !== 6'b0) $display("FAIL rm_async got %b want 000000", vec); else pass_cnt++;
      have_eval = 1'b0; exp_wait = 0; exp_own = 0;
      @(posedge clk);
      #1;
      chk_cnt++; if (vec !== 6'b0) $display("FAIL rm_no_rvalid got %b want 000000", vec); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; i_req = 1'b1; i_addr = 32'h1C; d_req = 1'b0;
      #1;
      eval(); have_eval = 1'b1;
      chk_cnt++; if (vec !== 6'b101000) $display("FAIL rm_first_fetch got %b want 101000", vec); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'h1C, 1'b1, 1'b0, 32'h4C, 32'h0);
         chk_cnt++;
         if (i_gnt !== (k == 4)) $display("FAIL rm_force cyc %0d got %b want %b", k, i_gnt, k == 4);
         else pass_cnt++;
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_random();
      logic ir, dr, dw;
      logic [31:0] ia, da, wd;
      for (int n = 0; n < 400; n++) begin
         ir = ($urandom_range(99) < 70);
         dr = ($urandom_range(99) < 60);
         dw = ($urandom_range(99) < 40);
         ia = {24'h0, 6'($urandom_range(63)), 2'b00};
         da = {24'h0, 6'($urandom_range(63)), 2'b00};
         wd = $urandom;
         drive(ir, ia, dr, dw, da, wd);
         chk_cnt++; if (vec !== exp_vec) $display("FAIL rnd_vec cyc %0d got %b want %b", n, vec, exp_vec); else pass_cnt++;
         if (e_ig || e_dg) begin
            chk_cnt++; if (m_addr !== exp_addr) $display("FAIL rnd_addr cyc %0d got %h want %h", n, m_addr, exp_addr); else pass_cnt++;
         end
         if (e_dg && dw) begin
            chk_cnt++; if (m_wdata !== wd) $display("FAIL rnd_wdata cyc %0d got %h want %h", n, m_wdata, wd); else pass_cnt++;
         end
         if (exp_own == 1) begin
            chk_cnt++; if (i_rdata !== exp_rdata) $display("FAIL rnd_irdata cyc %0d got %h want %h", n, i_rdata, exp_rdata); else pass_cnt++;
         end else if (exp_own == 2) begin
            chk_cnt++; if (d_rdata !== exp_rdata) $display("FAIL rnd_drdata cyc %0d got %h want %h", n, d_rdata, exp_rdata); else pass_cnt++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b1; have_eval = 1'b0;
      i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      exp_wait = 0; exp_own = 0; exp_rdata = 32'h0; e_ig = 1'b0; e_dg = 1'b0;
      for (int i = 0; i < 64; i++) shadow[i] = word_at(i);
      #1;
      test_reset();
      test_fetch_only();
      test_contention();
      test_starvation();
      test_store_load();
      test_withdrawal();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
